reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue between rename/issue and the architectural register/flag state.
//  - Rename allocates one entry per cycle; FUs mark entries complete out of order.
//  - Retires at most one done head entry per cycle and drives the arch state commit interface:
//    physical register free/set, flag write and mispredict rollback.
//  - A mispredicted branch at the head flushes the buffer and drives the fetch redirect.
// PARAMETERS
//  ROB_DEPTH     16                 entries; power of two, >=4
//  NUM_PHYS_REG  pkg (128)          physical registers; tag width = $clog2(NUM_PHYS_REG)
//  NUM_FLAGS     pkg                architectural flag bits
//  NUM_FU        pkg                completion ports
//  WORD_SIZE_P   pkg                PC/data width
// PORTS
//  clk_i               in   1                          clock
//  reset_n_i           in   1                          synchronous active-low reset
//  alloc_v_i           in   1                          allocate request from rename
//  alloc_ready_o       out  1                          entry available this cycle
//  alloc_idx_o         out  $clog2(ROB_DEPTH)          index (tail) given to the allocated op
//  alloc_has_dest_i    in   1                          op writes a physical register
//  alloc_phys_new_i    in   $clog2(NUM_PHYS_REG)       newly mapped phys reg
//  alloc_phys_old_i    in   $clog2(NUM_PHYS_REG)       previous mapping, freed at commit
//  alloc_flag_mask_i   in   NUM_FLAGS                  flags the op writes
//  alloc_is_br_i       in   1                          op is a branch
//  exe_done_v_i        in   NUM_FU                     completion valid per FU
//  exe_done_idx_i      in   NUM_FU x $clog2(ROB_DEPTH) completing entry
//  exe_flags_i         in   NUM_FU x NUM_FLAGS         flag results
//  exe_mispredict_i    in   NUM_FU                     branch resolved mispredicted
//  exe_target_i        in   NUM_FU x WORD_SIZE_P       correct branch target
//  rob_phys_valid_o    out  1                          commit of a dest-writing op
//  rob_phys_reg_cl_o   out  $clog2(NUM_PHYS_REG)       phys reg to free (old)
//  rob_phys_reg_set_o  out  $clog2(NUM_PHYS_REG)       phys reg made architectural (new)
//  rob_phys_mispredict_o out 1                         rollback speculative valids
//  rob_flag_valid_o    out  1                          flag write at commit
//  rob_flag_o          out  2*NUM_FLAGS                {mask, values}
//  redirect_v_o        out  1                          fetch redirect; equals mispredict
//  redirect_pc_o       out  WORD_SIZE_P                redirect target
//  count_o             out  $clog2(ROB_DEPTH)+1        occupied entries
// BEHAVIOUR
//  - State: head, tail ptrs plus count; per entry valid, done, has_dest, is_br, mispred,
//    phys_new, phys_old, flag mask/values, target.
//  - Reset (reset_n_i=0 at posedge): head=tail=count=0; all entry valid/done=0.
//    Every output is 0 except alloc_ready_o=1.
//  - Alloc:
//    - alloc_ready_o = (count<ROB_DEPTH) && !rob_phys_mispredict_o; no credit for a same-cycle commit.
//    - alloc_v_i && alloc_ready_o writes entry[tail] with done=0, then tail+1 (mod ROB_DEPTH).
//    - alloc_idx_o = tail, combinational.
//  - Complete:
//    - exe_done_v_i[i] writes flags, mispred and target into entry[idx] and sets done at the posedge.
//    - Completions to non-valid entries are ignored.
//    - Two FUs with the same idx in one cycle is illegal (assertion).
//  - Commit:
//    - The head entry is eligible when valid && done (registered).
//    - A completion is not bypassed to commit: earliest commit is the cycle after done is set.
//    - Commit outputs are combinational from head state and pulse for exactly the commit cycle.
//    - rob_phys_valid_o = commit && has_dest.
//    - rob_flag_valid_o = commit && |mask.
//    - On commit: head+1, count-1, entry valid cleared.
//  - Mispredict:
//    - Triggered when the committing head has is_br && mispred.
//    - The branch still commits (phys/flag outputs as normal).
//    - rob_phys_mispredict_o=redirect_v_o=1 and redirect_pc_o=target, same cycle.
//    - Next cycle: head=tail=count=0, all valid cleared; same-cycle alloc and completions are dropped.
//  - Simultaneous alloc+commit: count unchanged; pointers both advance.
//  - Full: tail==head && count==ROB_DEPTH.
//  - Reset mid-operation discards all entries without any commit pulse.
// CONFIGURATION
//  ROB_PERF_CNT_EN:
//    - Defined: adds ports perf_commit_o and perf_flush_o (32 bits each, out).
//      Counters of commits and mispredict flushes; wrap at 2^32; cleared by reset.
//    - Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Purple_Jade_pkg: NUM_PHYS_REG, NUM_FLAGS, NUM_FU, WORD_SIZE_P, ROB_DEPTH default,
//    rob_entry_t struct, rob_idx_t typedef.
//  - Sub-module rob_ptr_ctrl: head/tail/count update, full/empty, flush clear.
//  - Entry array and commit decode stay in reorder_buffer.
// TESTING
//  - Reset, then 3 allocs (new 16/17/18, old 1/2/3) completed in order 2,0,1:
//    commits in order 0,1,2 with cl=1,2,3 and set=16,17,18.
//  - Fill 16 entries: alloc_ready_o=0 and count_o=16. Complete and commit head: ready returns next cycle.
//  - Branch at idx 1 with mispredict and target 0x40, entries 2-5 done:
//    entry 1 commits with mispredict=redirect_v=1 and pc=0x40; next cycle count_o=0 and no commit of 2-5.
//  - Commit with flag mask 4'b0011 and values 4'b0101: rob_flag_valid_o=1 and rob_flag_o={4'b0011,4'b0101}.
//    No-dest op gives rob_phys_valid_o=0.
//  - Wrap: 40 alloc/commit pairs with 1 cycle latency keep count_o<=2. Indices wrap 15->0 without loss.
//  - Assert reset_n_i with 5 entries live: all outputs 0 next cycle and count_o=0.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Shared types and sizing for the reorder buffer.
// Contents: physical register / flag / FU / word sizing, default ROB depth,
// rob_idx_t index type and the rob_entry_t per-entry state record.
package Purple_Jade_pkg;

  localparam int unsigned NUM_PHYS_REG      = 128;
  localparam int unsigned NUM_FLAGS         = 4;
  localparam int unsigned NUM_FU            = 2;
  localparam int unsigned WORD_SIZE_P       = 32;
  localparam int unsigned ROB_DEPTH_DEFAULT = 16;
  localparam int unsigned PHYS_W            = $clog2(NUM_PHYS_REG);

  typedef logic [$clog2(ROB_DEPTH_DEFAULT)-1:0] rob_idx_t;
  typedef logic [PHYS_W-1:0]                    phys_reg_t;

  typedef struct packed {
    logic                   valid;
    logic                   done;
    logic                   has_dest;
    logic                   is_br;
    logic                   mispred;
    phys_reg_t              phys_new;
    phys_reg_t              phys_old;
    logic [NUM_FLAGS-1:0]   flag_mask;
    logic [NUM_FLAGS-1:0]   flag_val;
    logic [WORD_SIZE_P-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer.
// Ports:
//   clk_i, reset_n_i   clock, synchronous active-low reset
//   alloc_i            an entry is written at tail this cycle
//   commit_i           the head entry retires this cycle
//   flush_i            mispredict flush: everything returns to empty
//   head_o, tail_o     current pointers
//   count_o            occupied entries
//   full_o, empty_o    occupancy flags
module rob_ptr_ctrl #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     alloc_i,
  input  logic                     commit_i,
  input  logic                     flush_i,
  output logic [$clog2(Depth)-1:0] head_o,
  output logic [$clog2(Depth)-1:0] tail_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = IdxW + 1;

  logic [IdxW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  // Depth is a power of two, so pointer increments wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_i) head_d = head_q + IdxW'(1);
      if (alloc_i)  tail_d = tail_q + IdxW'(1);
      unique case ({alloc_i, commit_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth)) && (head_q == tail_q);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue between rename/issue and architectural state.
// Rename allocates one entry per cycle at tail; FUs mark entries done out of
// order; the head retires once done (registered), driving the physical
// register free/set, flag write and, for a mispredicted branch, a rollback
// plus fetch redirect followed by a full flush.
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   alloc_*                   allocation request, ready and assigned index
//   exe_*                     per-FU completion (idx, flags, mispredict, target)
//   rob_phys_*, rob_flag_*    commit interface to arch state
//   redirect_v_o/pc_o         fetch redirect on mispredict
//   count_o                   occupied entries
// Build option ROB_PERF_CNT_EN adds perf_commit_o / perf_flush_o event counters.
module reorder_buffer
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        alloc_v_i,
  output logic                                        alloc_ready_o,
  output logic [$clog2(ROB_DEPTH)-1:0]                alloc_idx_o,
  input  logic                                        alloc_has_dest_i,
  input  logic [PHYS_W-1:0]                           alloc_phys_new_i,
  input  logic [PHYS_W-1:0]                           alloc_phys_old_i,
  input  logic [NUM_FLAGS-1:0]                        alloc_flag_mask_i,
  input  logic                                        alloc_is_br_i,
  input  logic [NUM_FU-1:0]                           exe_done_v_i,
  input  logic [NUM_FU-1:0][$clog2(ROB_DEPTH)-1:0]    exe_done_idx_i,
  input  logic [NUM_FU-1:0][NUM_FLAGS-1:0]            exe_flags_i,
  input  logic [NUM_FU-1:0]                           exe_mispredict_i,
  input  logic [NUM_FU-1:0][WORD_SIZE_P-1:0]          exe_target_i,
  output logic                                        rob_phys_valid_o,
  output logic [PHYS_W-1:0]                           rob_phys_reg_cl_o,
  output logic [PHYS_W-1:0]                           rob_phys_reg_set_o,
  output logic                                        rob_phys_mispredict_o,
  output logic                                        rob_flag_valid_o,
  output logic [2*NUM_FLAGS-1:0]                      rob_flag_o,
  output logic                                        redirect_v_o,
  output logic [WORD_SIZE_P-1:0]                      redirect_pc_o,
  output logic [$clog2(ROB_DEPTH):0]                  count_o
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                                 perf_commit_o,
  output logic [31:0]                                 perf_flush_o
`endif
);

  localparam int unsigned IdxW = $clog2(ROB_DEPTH);

  rob_entry_t      entries_q [ROB_DEPTH];
  rob_entry_t      entries_d [ROB_DEPTH];
  rob_entry_t      head_entry;
  logic [IdxW-1:0] head, tail;
  logic [IdxW:0]   count;
  logic            full, empty;
  logic            alloc_fire, commit, flush;

  rob_ptr_ctrl #(
    .Depth (ROB_DEPTH)
  ) u_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .alloc_i   (alloc_fire),
    .commit_i  (commit),
    .flush_i   (flush),
    .head_o    (head),
    .tail_o    (tail),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign head_entry    = entries_q[head];
  // done is registered, so a completion is never bypassed into the same-cycle commit.
  assign commit        = !empty && head_entry.valid && head_entry.done;
  assign flush         = commit && head_entry.is_br && head_entry.mispred;
  // No credit is given for a same-cycle commit: a full buffer stays full this cycle.
  assign alloc_ready_o = !full && !flush;
  assign alloc_fire    = alloc_v_i && alloc_ready_o;
  assign alloc_idx_o   = tail;
  assign count_o       = count;

  always_comb begin
    entries_d = entries_q;
    if (flush) begin
      // Younger ops behind the mispredicted branch are discarded, including
      // anything completing or allocating in the flush cycle.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (exe_done_v_i[f] && entries_q[exe_done_idx_i[f]].valid) begin
          entries_d[exe_done_idx_i[f]].done     = 1'b1;
          entries_d[exe_done_idx_i[f]].flag_val = exe_flags_i[f];
          entries_d[exe_done_idx_i[f]].mispred  = exe_mispredict_i[f];
          entries_d[exe_done_idx_i[f]].target   = exe_target_i[f];
        end
      end
      if (commit) begin
        entries_d[head].valid = 1'b0;
        entries_d[head].done  = 1'b0;
      end
      if (alloc_fire) begin
        entries_d[tail].valid     = 1'b1;
        entries_d[tail].done      = 1'b0;
        entries_d[tail].has_dest  = alloc_has_dest_i;
        entries_d[tail].is_br     = alloc_is_br_i;
        entries_d[tail].mispred   = 1'b0;
        entries_d[tail].phys_new  = alloc_phys_new_i;
        entries_d[tail].phys_old  = alloc_phys_old_i;
        entries_d[tail].flag_mask = alloc_flag_mask_i;
        entries_d[tail].flag_val  = '0;
        entries_d[tail].target    = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  // Commit decode; data outputs are zeroed outside their valid pulse.
  always_comb begin
    rob_phys_valid_o      = commit && head_entry.has_dest;
    rob_flag_valid_o      = commit && |head_entry.flag_mask;
    rob_phys_mispredict_o = flush;
    redirect_v_o          = flush;
    rob_phys_reg_cl_o     = rob_phys_valid_o ? head_entry.phys_old : '0;
    rob_phys_reg_set_o    = rob_phys_valid_o ? head_entry.phys_new : '0;
    rob_flag_o            = rob_flag_valid_o ? {head_entry.flag_mask, head_entry.flag_val} : '0;
    redirect_pc_o         = flush ? head_entry.target : '0;
  end

  for (genvar a = 0; a < NUM_FU; a++) begin : g_fu_a
    for (genvar b = a + 1; b < NUM_FU; b++) begin : g_fu_b
      a_unique_done_idx : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(exe_done_v_i[a] && exe_done_v_i[b] && (exe_done_idx_i[a] == exe_done_idx_i[b])));
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_q, perf_flush_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      perf_commit_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (commit) perf_commit_q <= perf_commit_q + 32'd1;
      if (flush)  perf_flush_q  <= perf_flush_q + 32'd1;
    end
  end

  assign perf_commit_o = perf_commit_q;
  assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import Purple_Jade_pkg::*;

  localparam int unsigned IdxW = $clog2(ROB_DEPTH_DEFAULT);

  typedef struct {
    logic                 has_dest;
    logic [PHYS_W-1:0]    phys_new;
    logic [PHYS_W-1:0]    phys_old;
    logic [NUM_FLAGS-1:0] mask;
  } exp_t;

  logic                                 clk_i = 1'b0;
  logic                                 reset_n_i;
  logic                                 alloc_v_i;
  logic                                 alloc_ready_o;
  logic [IdxW-1:0]                      alloc_idx_o;
  logic                                 alloc_has_dest_i;
  logic [PHYS_W-1:0]                    alloc_phys_new_i, alloc_phys_old_i;
  logic [NUM_FLAGS-1:0]                 alloc_flag_mask_i;
  logic                                 alloc_is_br_i;
  logic [NUM_FU-1:0]                    exe_done_v_i;
  logic [NUM_FU-1:0][IdxW-1:0]          exe_done_idx_i;
  logic [NUM_FU-1:0][NUM_FLAGS-1:0]     exe_flags_i;
  logic [NUM_FU-1:0]                    exe_mispredict_i;
  logic [NUM_FU-1:0][WORD_SIZE_P-1:0]   exe_target_i;
  logic                                 rob_phys_valid_o;
  logic [PHYS_W-1:0]                    rob_phys_reg_cl_o, rob_phys_reg_set_o;
  logic                                 rob_phys_mispredict_o;
  logic                                 rob_flag_valid_o;
  logic [2*NUM_FLAGS-1:0]               rob_flag_o;
  logic                                 redirect_v_o;
  logic [WORD_SIZE_P-1:0]               redirect_pc_o;
  logic [IdxW:0]                        count_o;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                          perf_commit_o, perf_flush_o;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk_i = ~clk_i;

  reorder_buffer #(
    .ROB_DEPTH (ROB_DEPTH_DEFAULT)
  ) dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .alloc_v_i             (alloc_v_i),
    .alloc_ready_o         (alloc_ready_o),
    .alloc_idx_o           (alloc_idx_o),
    .alloc_has_dest_i      (alloc_has_dest_i),
    .alloc_phys_new_i      (alloc_phys_new_i),
    .alloc_phys_old_i      (alloc_phys_old_i),
    .alloc_flag_mask_i     (alloc_flag_mask_i),
    .alloc_is_br_i         (alloc_is_br_i),
    .exe_done_v_i          (exe_done_v_i),
    .exe_done_idx_i        (exe_done_idx_i),
    .exe_flags_i           (exe_flags_i),
    .exe_mispredict_i      (exe_mispredict_i),
    .exe_target_i          (exe_target_i),
    .rob_phys_valid_o      (rob_phys_valid_o),
    .rob_phys_reg_cl_o     (rob_phys_reg_cl_o),
    .rob_phys_reg_set_o    (rob_phys_reg_set_o),
    .rob_phys_mispredict_o (rob_phys_mispredict_o),
    .rob_flag_valid_o      (rob_flag_valid_o),
    .rob_flag_o            (rob_flag_o),
    .redirect_v_o          (redirect_v_o),
    .redirect_pc_o         (redirect_pc_o),
    .count_o               (count_o)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commit_o         (perf_commit_o),
    .perf_flush_o          (perf_flush_o)
`endif
  );

  // One clock; inputs are one-shot and cleared after the edge that consumes them.
  task automatic step();
    @(posedge clk_i);
    #1;
    alloc_v_i        = 1'b0;
    exe_done_v_i     = '0;
    exe_mispredict_i = '0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    sb.delete();
  endtask

  task automatic drive_alloc(input logic hd, input logic [PHYS_W-1:0] nw,
                             input logic [PHYS_W-1:0] old, input logic [NUM_FLAGS-1:0] mask,
                             input logic br);
    exp_t x;
    alloc_v_i         = 1'b1;
    alloc_has_dest_i  = hd;
    alloc_phys_new_i  = nw;
    alloc_phys_old_i  = old;
    alloc_flag_mask_i = mask;
    alloc_is_br_i     = br;
    x.has_dest = hd;
    x.phys_new = nw;
    x.phys_old = old;
    x.mask     = mask;
    sb.push_back(x);
  endtask

  task automatic drive_done(input int f, input logic [IdxW-1:0] idx,
                            input logic [NUM_FLAGS-1:0] fl, input logic mp,
                            input logic [WORD_SIZE_P-1:0] tgt);
    exe_done_v_i[f]     = 1'b1;
    exe_done_idx_i[f]   = idx;
    exe_flags_i[f]      = fl;
    exe_mispredict_i[f] = mp;
    exe_target_i[f]     = tgt;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    n_checks++; if (alloc_ready_o !== 1'b1) $display("FAIL reset_ready: got %0d want 1", alloc_ready_o); else n_pass++;
    n_checks++; if (count_o !== '0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
    n_checks++; if (alloc_idx_o !== '0) $display("FAIL reset_idx: got %0d want 0", alloc_idx_o); else n_pass++;
    n_checks++; if (rob_phys_valid_o !== 1'b0) $display("FAIL reset_phys_valid: got %0d want 0", rob_phys_valid_o); else n_pass++;
    n_checks++; if (rob_flag_valid_o !== 1'b0 || rob_flag_o !== '0) $display("FAIL reset_flag: got %0d/%0h want 0/0", rob_flag_valid_o, rob_flag_o); else n_pass++;
    n_checks++; if (rob_phys_mispredict_o !== 1'b0 || redirect_v_o !== 1'b0 || redirect_pc_o !== '0) $display("FAIL reset_redirect: got %0d/%0d/%0h want 0/0/0", rob_phys_mispredict_o, redirect_v_o, redirect_pc_o); else n_pass++;
    n_checks++; if (rob_phys_reg_cl_o !== '0 || rob_phys_reg_set_o !== '0) $display("FAIL reset_regs: got %0d/%0d want 0/0", rob_phys_reg_cl_o, rob_phys_reg_set_o); else n_pass++;
  endtask

  task automatic test_in_order();
    int got;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (alloc_idx_o !== IdxW'(i)) $display("FAIL inorder_idx: got %0d want %0d", alloc_idx_o, i); else n_pass++;
      drive_alloc(1'b1, PHYS_W'(16 + i), PHYS_W'(1 + i), '0, 1'b0);
      step();
    end
    n_checks++; if (count_o !== 5'd3) $display("FAIL inorder_count: got %0d want 3", count_o); else n_pass++;
    drive_done(0, 4'd2, '0, 1'b0, '0);
    step();
    n_checks++; if (rob_phys_valid_o !== 1'b0) $display("FAIL inorder_early_commit: got %0d want 0", rob_phys_valid_o); else n_pass++;
    drive_done(0, 4'd0, '0, 1'b0, '0);
    step();
    drive_done(0, 4'd1, '0, 1'b0, '0);
    got = 0;
    for (int cyc = 0; cyc < 8 && got < 3; cyc++) begin
      if (rob_phys_valid_o === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (rob_phys_reg_cl_o !== e.phys_old || rob_phys_reg_set_o !== e.phys_new) $display("FAIL inorder_commit: got cl=%0d set=%0d want cl=%0d set=%0d", rob_phys_reg_cl_o, rob_phys_reg_set_o, e.phys_old, e.phys_new); else n_pass++;
        got++;
      end
      if (got < 3) step();
    end
    n_checks++; if (got !== 3) $display("FAIL inorder_commit_count: got %0d want 3", got); else n_pass++;
    step();
    n_checks++; if (count_o !== '0) $display("FAIL inorder_drain: got %0d want 0", count_o); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(1'b1, PHYS_W'(32 + i), PHYS_W'(64 + i), '0, 1'b0);
      step();
    end
    n_checks++; if (alloc_ready_o !== 1'b0) $display("FAIL full_ready: got %0d want 0", alloc_ready_o); else n_pass++;
    n_checks++; if (count_o !== 5'd16) $display("FAIL full_count: got %0d want 16", count_o); else n_pass++;
    alloc_v_i = 1'b1;  // must be ignored while full
    step();
    n_checks++; if (count_o !== 5'd16 || alloc_idx_o !== '0) $display("FAIL full_overflow: got count=%0d idx=%0d want 16/0", count_o, alloc_idx_o); else n_pass++;
    drive_done(1, 4'd0, '0, 1'b0, '0);
    step();
    e = sb.pop_front();
    n_checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== e.phys_old) $display("FAIL full_commit: got v=%0d cl=%0d want 1/%0d", rob_phys_valid_o, rob_phys_reg_cl_o, e.phys_old); else n_pass++;
    n_checks++; if (alloc_ready_o !== 1'b0) $display("FAIL full_no_credit: got %0d want 0", alloc_ready_o); else n_pass++;
    step();
    n_checks++; if (alloc_ready_o !== 1'b1 || count_o !== 5'd15) $display("FAIL full_ready_back: got ready=%0d count=%0d want 1/15", alloc_ready_o, count_o); else n_pass++;
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_alloc(1'b1, 7'd20, 7'd4, '0, 1'b0); step();
    drive_alloc(1'b0, 7'd0, 7'd0, '0, 1'b1);  step();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(1'b1, PHYS_W'(21 + i), PHYS_W'(5 + i), '0, 1'b0);
      step();
    end
    drive_done(0, 4'd2, '0, 1'b0, '0);
    drive_done(1, 4'd3, '0, 1'b0, '0);
    step();
    drive_done(0, 4'd0, '0, 1'b0, '0);
    drive_done(1, 4'd4, '0, 1'b0, '0);
    step();
    e = sb.pop_front();
    n_checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_cl_o !== e.phys_old || rob_phys_mispredict_o !== 1'b0) $display("FAIL br_pre_commit: got v=%0d cl=%0d mp=%0d want 1/%0d/0", rob_phys_valid_o, rob_phys_reg_cl_o, rob_phys_mispredict_o, e.phys_old); else n_pass++;
    drive_done(0, 4'd1, '0, 1'b1, 32'h40);
    drive_done(1, 4'd5, '0, 1'b0, '0);
    step();
    e = sb.pop_front();
    n_checks++; if (rob_phys_mispredict_o !== 1'b1 || redirect_v_o !== 1'b1) $display("FAIL br_mispredict: got mp=%0d rv=%0d want 1/1", rob_phys_mispredict_o, redirect_v_o); else n_pass++;
    n_checks++; if (redirect_pc_o !== 32'h40) $display("FAIL br_pc: got %0h want 40", redirect_pc_o); else n_pass++;
    n_checks++; if (rob_phys_valid_o !== e.has_dest) $display("FAIL br_phys_valid: got %0d want %0d", rob_phys_valid_o, e.has_dest); else n_pass++;
    n_checks++; if (alloc_ready_o !== 1'b0) $display("FAIL br_ready: got %0d want 0", alloc_ready_o); else n_pass++;
    alloc_v_i = 1'b1;  // dropped by the flush
    step();
    n_checks++; if (count_o !== '0 || alloc_idx_o !== '0) $display("FAIL br_flush: got count=%0d idx=%0d want 0/0", count_o, alloc_idx_o); else n_pass++;
    n_checks++; if (rob_phys_valid_o !== 1'b0 || rob_phys_mispredict_o !== 1'b0) $display("FAIL br_after: got v=%0d mp=%0d want 0/0", rob_phys_valid_o, rob_phys_mispredict_o); else n_pass++;
    step();
    n_checks++; if (rob_phys_valid_o !== 1'b0 || count_o !== '0) $display("FAIL br_no_younger: got v=%0d count=%0d want 0/0", rob_phys_valid_o, count_o); else n_pass++;
  endtask

  task automatic test_flags();
    do_reset();
    drive_alloc(1'b0, 7'd0, 7'd0, 4'b0011, 1'b0); step();
    drive_alloc(1'b1, 7'd40, 7'd5, 4'b0000, 1'b0); step();
    drive_done(0, 4'd0, 4'b0101, 1'b0, '0);
    step();
    e = sb.pop_front();
    n_checks++; if (rob_flag_valid_o !== (|e.mask)) $display("FAIL flag_valid: got %0d want %0d", rob_flag_valid_o, |e.mask); else n_pass++;
    n_checks++; if (rob_flag_o !== {e.mask, 4'b0101}) $display("FAIL flag_value: got %0h want %0h", rob_flag_o, {e.mask, 4'b0101}); else n_pass++;
    n_checks++; if (rob_phys_valid_o !== 1'b0) $display("FAIL flag_nodest: got %0d want 0", rob_phys_valid_o); else n_pass++;
    drive_done(1, 4'd1, 4'b1111, 1'b0, '0);
    step();
    e = sb.pop_front();
    n_checks++; if (rob_phys_valid_o !== 1'b1 || rob_phys_reg_set_o !== e.phys_new || rob_flag_valid_o !== 1'b0) $display("FAIL flag_dest_commit: got v=%0d set=%0d fv=%0d want 1/%0d/0", rob_phys_valid_o, rob_phys_reg_set_o, rob_flag_valid_o, e.phys_new); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [IdxW-1:0] exp_idx;
    logic [IdxW-1:0] di;
    int got, bad_cnt, bad_cmp;
    do_reset();
    exp_idx = '0;
    got = 0; bad_cnt = 0; bad_cmp = 0;
    for (int k = 0; k < 44; k++) begin
      if (k < 40) begin
        if (alloc_idx_o !== exp_idx) bad_cmp++;
        drive_alloc(1'b1, PHYS_W'(50 + k), PHYS_W'(k), '0, 1'b0);
        exp_idx = exp_idx + 1'b1;
      end
      if (k >= 1 && k <= 40) begin
        di = IdxW'(k - 1);
        drive_done(k % 2, di, '0, 1'b0, '0);
      end
      step();
      if (count_o > 5'd2) bad_cnt++;
      if (rob_phys_valid_o === 1'b1) begin
        if (sb.size() == 0) bad_cmp++;
        else begin
          e = sb.pop_front();
          if (rob_phys_reg_cl_o !== e.phys_old || rob_phys_reg_set_o !== e.phys_new) bad_cmp++;
          got++;
        end
      end
    end
    n_checks++; if (got !== 40) $display("FAIL wrap_commits: got %0d want 40", got); else n_pass++;
    n_checks++; if (bad_cnt !== 0) $display("FAIL wrap_count_bound: got %0d cycles over 2 want 0", bad_cnt); else n_pass++;
    n_checks++; if (bad_cmp !== 0) $display("FAIL wrap_order: got %0d mismatched idx/commits want 0", bad_cmp); else n_pass++;
    n_checks++; if (count_o !== '0) $display("FAIL wrap_drain: got %0d want 0", count_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1'b1, PHYS_W'(90 + i), PHYS_W'(100 + i), 4'b0001, 1'b0);
      step();
    end
    drive_done(0, 4'd0, 4'b0001, 1'b0, '0);
    step();
    n_checks++; if (rob_phys_valid_o !== 1'b1 || count_o !== 5'd5) $display("FAIL rmid_pre: got v=%0d count=%0d want 1/5", rob_phys_valid_o, count_o); else n_pass++;
    reset_n_i = 1'b0;
    alloc_v_i = 1'b1;
    step();
    n_checks++; if (count_o !== '0 || alloc_idx_o !== '0) $display("FAIL rmid_count: got count=%0d idx=%0d want 0/0", count_o, alloc_idx_o); else n_pass++;
    n_checks++; if (rob_phys_valid_o !== 1'b0 || rob_flag_valid_o !== 1'b0 || rob_flag_o !== '0) $display("FAIL rmid_commit: got v=%0d fv=%0d f=%0h want 0/0/0", rob_phys_valid_o, rob_flag_valid_o, rob_flag_o); else n_pass++;
    n_checks++; if (rob_phys_reg_cl_o !== '0 || rob_phys_reg_set_o !== '0 || redirect_v_o !== 1'b0 || redirect_pc_o !== '0) $display("FAIL rmid_outs: got cl=%0d set=%0d rv=%0d pc=%0h want all 0", rob_phys_reg_cl_o, rob_phys_reg_set_o, redirect_v_o, redirect_pc_o); else n_pass++;
    n_checks++; if (alloc_ready_o !== 1'b1) $display("FAIL rmid_ready: got %0d want 1", alloc_ready_o); else n_pass++;
    reset_n_i = 1'b1;
    sb.delete();
  endtask

  initial begin
    reset_n_i         = 1'b0;
    alloc_v_i         = 1'b0;
    alloc_has_dest_i  = 1'b0;
    alloc_phys_new_i  = '0;
    alloc_phys_old_i  = '0;
    alloc_flag_mask_i = '0;
    alloc_is_br_i     = 1'b0;
    exe_done_v_i      = '0;
    exe_done_idx_i    = '0;
    exe_flags_i       = '0;
    exe_mispredict_i  = '0;
    exe_target_i      = '0;
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_flags();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
